// File: rtl/majority_circuit.sv
// Three-input majority voter for triplicated control signals. Drives a zero-latency
// voted output plus enable-qualified registered status and a saturating vote-1 counter.
module majority_circuit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             en,
    input  logic             clr,
    output logic             out,
    output logic             out_q,
    output logic             unanimous,
    output logic [2:0]       dissent,
    output logic [CNT_W-1:0] maj_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    function automatic logic maj3(input logic [2:0] v);
        return (v[2] & v[1]) | (v[1] & v[0]) | (v[2] & v[0]);
    endfunction

    function automatic logic all_equal(input logic [2:0] v);
        return (&v) | ~(|v);
    endfunction

    logic [2:0]       votes_s;
    logic             maj_s;
    logic             vote_d, vote_q;
    logic             unan_d, unan_q;
    logic [2:0]       dis_d, dis_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign votes_s = {a, b, c};
    assign maj_s   = maj3(votes_s);
    assign out     = maj_s;

    // Next-state for status registers and the vote-1 counter; clear outranks counting.
    always_comb begin
        vote_d = vote_q;
        unan_d = unan_q;
        dis_d  = dis_q;
        cnt_d  = cnt_q;
        if (en) begin
            vote_d = maj_s;
            unan_d = all_equal(votes_s);
            // XOR against the vote leaves only the outvoted input set
            dis_d  = votes_s ^ {3{maj_s}};
        end else begin
            vote_d = vote_q;
            unan_d = unan_q;
            dis_d  = dis_q;
        end
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (en && maj_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Status and counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q <= 1'b0;
            unan_q <= 1'b0;
            dis_q  <= 3'b000;
            cnt_q  <= CNT_ZERO;
        end else begin
            vote_q <= vote_d;
            unan_q <= unan_d;
            dis_q  <= dis_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_q     = vote_q;
    assign unanimous = unan_q;
    assign dissent   = dis_q;
    assign maj_cnt   = cnt_q;

endmodule

// File: tb/tb_majority_circuit.sv
// Scoreboard bench for majority_circuit: a wide-counter and a 2-bit-counter instance
// share stimulus; a count-based reference model queues expectations per clock edge.
module tb_majority_circuit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, en = 1'b0, clr = 1'b0;

    logic        out_w, oq_w, un_w;
    logic [2:0]  ds_w;
    logic [15:0] cnt_w;
    logic        out_s, oq_s, un_s;
    logic [2:0]  ds_s;
    logic [1:0]  cnt_s;

    majority_circuit #(.CNT_W(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .out(out_w), .a(a), .b(b), .c(c), .en(en), .clr(clr),
        .out_q(oq_w), .unanimous(un_w), .dissent(ds_w), .maj_cnt(cnt_w)
    );

    majority_circuit #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .out(out_s), .a(a), .b(b), .c(c), .en(en), .clr(clr),
        .out_q(oq_s), .unanimous(un_s), .dissent(ds_s), .maj_cnt(cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        maj;
        logic        oq;
        logic        un;
        logic [2:0]  ds;
        int          cw;
        int          cs;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Reference state
    logic m_oq = 1'b0, m_un = 1'b0;
    logic [2:0] m_ds = 3'b000;
    int m_cw = 0, m_cs = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic ref_maj(input logic [2:0] v);
        return $countones(v) >= 2;
    endfunction

    function automatic logic [2:0] ref_dissent(input logic [2:0] v);
        int n;
        n = $countones(v);
        if (n == 1) return v;
        if (n == 2) return ~v;
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_oq = 1'b0; m_un = 1'b0; m_ds = 3'b000; m_cw = 0; m_cs = 0;
    endtask

    task automatic step(input logic [2:0] v, input logic e, input logic cl);
        exp_t x;
        int n;
        @(negedge clk);
        {a, b, c} = v; en = e; clr = cl;
        n = $countones(v);
        if (e) begin
            m_oq = ref_maj(v);
            m_un = (n == 0) || (n == 3);
            m_ds = ref_dissent(v);
        end
        if (cl) begin
            m_cw = 0; m_cs = 0;
        end else if (e && ref_maj(v)) begin
            if (m_cw < 65535) m_cw++;
            if (m_cs < 3) m_cs++;
        end
        x.maj = ref_maj(v); x.oq = m_oq; x.un = m_un; x.ds = m_ds; x.cw = m_cw; x.cs = m_cs;
        q.push_back(x);
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, "_oq_w"}, int'(oq_w), 0);
        chk({tag, "_un_w"}, int'(un_w), 0);
        chk({tag, "_ds_w"}, int'(ds_w), 0);
        chk({tag, "_cnt_w"}, int'(cnt_w), 0);
        chk({tag, "_oq_s"}, int'(oq_s), 0);
        chk({tag, "_cnt_s"}, int'(cnt_s), 0);
    endtask

    // Monitor: after each rising edge, compare DUT outputs against the queued expectation
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() != 0) begin
            x = q.pop_front();
            chk("out_w", int'(out_w), int'(x.maj));
            chk("out_s", int'(out_s), int'(x.maj));
            chk("out_q_w", int'(oq_w), int'(x.oq));
            chk("out_q_s", int'(oq_s), int'(x.oq));
            chk("unan_w", int'(un_w), int'(x.un));
            chk("unan_s", int'(un_s), int'(x.un));
            chk("dissent_w", int'(ds_w), int'(x.ds));
            chk("dissent_s", int'(ds_s), int'(x.ds));
            chk("cnt_w", int'(cnt_w), x.cw);
            chk("cnt_s", int'(cnt_s), x.cs);
        end
    end

    initial begin
        logic [2:0] v;
        #12 rst_n = 1'b1;

        // Combinational sweep with en=0, one pattern every 5 ns
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, c} = v;
            #1;
            chk("sweep_out_w", int'(out_w), int'(ref_maj(v)));
            chk("sweep_out_s", int'(out_s), int'(ref_maj(v)));
            #4;
        end
        chk_regs_zero("sweep");

        step(3'b110, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);
        step(3'b111, 1'b1, 1'b0);

        // Saturation of the 2-bit counter from zero
        step(3'b111, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(3'b111, 1'b1, 1'b0);

        // Clear and enable on the same edge with count at 2
        step(3'b000, 1'b0, 1'b1);
        step(3'b111, 1'b1, 1'b0);
        step(3'b111, 1'b1, 1'b0);
        step(3'b011, 1'b1, 1'b1);
        step(3'b100, 1'b0, 1'b0);

        // Asynchronous reset between edges with out_q=1
        step(3'b111, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        en = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_regs_zero("async_rst");
        {a, b, c} = 3'b001;
        #1 chk("rst_out_lo", int'(out_w), 0);
        {a, b, c} = 3'b011;
        #1 chk("rst_out_hi", int'(out_w), 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b101, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0));
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
